// File: rtl/prt_riscv_ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// prt_riscv_ram_arb_pkg : shared types and helpers for the two-port RAM arbiter
// Rev 1.0
// ============================================================================
package prt_riscv_ram_arb_pkg;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  typedef struct packed {
    logic  vld;
    port_t owner;
  } tag_t;

  localparam int P_LAT = 2;

  // Winner for this cycle; only meaningful when at least one port requests.
  function automatic port_t pick_port(input logic i_req, input logic d_req,
                                      input port_t last_gnt, input logic rr_en);
    port_t win;
    if (i_req && d_req) begin
      win = (rr_en && (last_gnt == PORT_D)) ? PORT_I : PORT_D;
    end else if (d_req) begin
      win = PORT_D;
    end else begin
      win = PORT_I;
    end
    return win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prt_riscv_ram_arb_tag.sv
`default_nettype none
// ============================================================================
// prt_riscv_ram_arb_tag : read-tag shift register matching the RAM read latency
// Rev 1.0
// ============================================================================
module prt_riscv_ram_arb_tag
  import prt_riscv_ram_arb_pkg::*;
#(
  parameter int P_LAT = 2
) (
  input  logic  CLK_IN,
  input  logic  RST_IN,
  input  logic  ISSUE_VLD_IN,
  input  port_t ISSUE_OWNER_IN,
  output logic  I_RD_VLD_OUT,
  output logic  D_RD_VLD_OUT
);

  tag_t tag_q [P_LAT];
  tag_t tag_d [P_LAT];

  always_comb begin
    tag_d[0].vld   = ISSUE_VLD_IN;
    tag_d[0].owner = ISSUE_OWNER_IN;
    for (int k = 1; k < P_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      for (int k = 0; k < P_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < P_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign I_RD_VLD_OUT = tag_q[P_LAT-1].vld & (tag_q[P_LAT-1].owner == PORT_I);
  assign D_RD_VLD_OUT = tag_q[P_LAT-1].vld & (tag_q[P_LAT-1].owner == PORT_D);

endmodule
`default_nettype wire

// File: rtl/prt_riscv_ram_arb.sv
`default_nettype none
// ============================================================================
// prt_riscv_ram_arb : shares one single-port RAM between instruction fetch and
// load/store. Define PRT_RISCV_RAM_ARB_RR_EN for round-robin, else D has priority.
// Rev 1.0
// ============================================================================
module prt_riscv_ram_arb
  import prt_riscv_ram_arb_pkg::*;
#(
  parameter int P_ADR = 10,
  parameter int P_LAT = prt_riscv_ram_arb_pkg::P_LAT
) (
  input  logic             RST_IN,
  input  logic             CLK_IN,
  input  logic             INIT_BUSY_IN,
  input  logic             I_RD_IN,
  input  logic [P_ADR-1:0] I_ADR_IN,
  output logic             I_ACK_OUT,
  output logic             I_RD_VLD_OUT,
  output logic [31:0]      I_RD_DAT_OUT,
  input  logic             D_RD_IN,
  input  logic             D_WR_IN,
  input  logic [P_ADR-1:0] D_ADR_IN,
  input  logic [31:0]      D_WR_DAT_IN,
  input  logic [3:0]       D_WR_STRB_IN,
  output logic             D_ACK_OUT,
  output logic             D_RD_VLD_OUT,
  output logic [31:0]      D_RD_DAT_OUT,
  output logic [P_ADR-1:0] RAM_ADR_OUT,
  output logic             RAM_RD_OUT,
  output logic             RAM_WR_OUT,
  output logic [31:0]      RAM_WR_DAT_OUT,
  output logic [3:0]       RAM_WR_STRB_OUT,
  input  logic [31:0]      RAM_RD_DAT_IN
);

`ifdef PRT_RISCV_RAM_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  port_t last_gnt_q;
  port_t last_gnt_d;
  port_t w_gnt;
  logic  w_i_req;
  logic  w_d_req;
  logic  w_issue;
  logic  w_rd;
  logic  w_wr;

  // Reset gates the issue path so no request leaks to the RAM while held in reset.
  always_comb begin
    w_i_req    = I_RD_IN;
    w_d_req    = D_RD_IN | D_WR_IN;
    w_issue    = ~RST_IN & ~INIT_BUSY_IN & (w_i_req | w_d_req);
    w_gnt      = pick_port(w_i_req, w_d_req, last_gnt_q, RR_EN);
    w_wr       = w_issue & (w_gnt == PORT_D) & D_WR_IN;
    w_rd       = w_issue & ~w_wr;
    last_gnt_d = w_issue ? w_gnt : last_gnt_q;
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      last_gnt_q <= PORT_D;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

  assign I_ACK_OUT       = w_issue & (w_gnt == PORT_I);
  assign D_ACK_OUT       = w_issue & (w_gnt == PORT_D);
  assign RAM_RD_OUT      = w_rd;
  assign RAM_WR_OUT      = w_wr;
  assign RAM_ADR_OUT     = (w_gnt == PORT_D) ? D_ADR_IN : I_ADR_IN;
  assign RAM_WR_DAT_OUT  = D_WR_DAT_IN;
  assign RAM_WR_STRB_OUT = w_wr ? D_WR_STRB_IN : 4'b0000;
  assign I_RD_DAT_OUT    = RAM_RD_DAT_IN;
  assign D_RD_DAT_OUT    = RAM_RD_DAT_IN;

  prt_riscv_ram_arb_tag #(
    .P_LAT (P_LAT)
  ) u_tag (
    .CLK_IN         (CLK_IN),
    .RST_IN         (RST_IN),
    .ISSUE_VLD_IN   (w_rd),
    .ISSUE_OWNER_IN (w_gnt),
    .I_RD_VLD_OUT   (I_RD_VLD_OUT),
    .D_RD_VLD_OUT   (D_RD_VLD_OUT)
  );

endmodule
`default_nettype wire

// File: tb/tb_prt_riscv_ram_arb.sv
`default_nettype none
// ============================================================================
// tb_prt_riscv_ram_arb : self-checking bench with a RAM model and a reference model
// Rev 1.0
// ============================================================================
module tb_prt_riscv_ram_arb;

  localparam int NWORDS = 256;
`ifdef PRT_RISCV_RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
  localparam int EXP_I_ACKS = 5;
  localparam int EXP_D_ACKS = 4;
`else
  localparam bit RR = 1'b0;
  localparam int EXP_I_ACKS = 1;
  localparam int EXP_D_ACKS = 8;
`endif

  logic        CLK_IN = 1'b0;
  logic        RST_IN = 1'b1;
  logic        INIT_BUSY_IN = 1'b0;
  logic        I_RD_IN = 1'b0;
  logic [9:0]  I_ADR_IN = '0;
  logic        I_ACK_OUT, I_RD_VLD_OUT;
  logic [31:0] I_RD_DAT_OUT;
  logic        D_RD_IN = 1'b0;
  logic        D_WR_IN = 1'b0;
  logic [9:0]  D_ADR_IN = '0;
  logic [31:0] D_WR_DAT_IN = '0;
  logic [3:0]  D_WR_STRB_IN = '0;
  logic        D_ACK_OUT, D_RD_VLD_OUT;
  logic [31:0] D_RD_DAT_OUT;
  logic [9:0]  RAM_ADR_OUT;
  logic        RAM_RD_OUT, RAM_WR_OUT;
  logic [31:0] RAM_WR_DAT_OUT;
  logic [3:0]  RAM_WR_STRB_OUT;
  logic [31:0] RAM_RD_DAT_IN;

  always #5 CLK_IN = ~CLK_IN;

  prt_riscv_ram_arb #(.P_ADR(10), .P_LAT(2)) dut (
    .RST_IN(RST_IN), .CLK_IN(CLK_IN), .INIT_BUSY_IN(INIT_BUSY_IN),
    .I_RD_IN(I_RD_IN), .I_ADR_IN(I_ADR_IN), .I_ACK_OUT(I_ACK_OUT),
    .I_RD_VLD_OUT(I_RD_VLD_OUT), .I_RD_DAT_OUT(I_RD_DAT_OUT),
    .D_RD_IN(D_RD_IN), .D_WR_IN(D_WR_IN), .D_ADR_IN(D_ADR_IN),
    .D_WR_DAT_IN(D_WR_DAT_IN), .D_WR_STRB_IN(D_WR_STRB_IN), .D_ACK_OUT(D_ACK_OUT),
    .D_RD_VLD_OUT(D_RD_VLD_OUT), .D_RD_DAT_OUT(D_RD_DAT_OUT),
    .RAM_ADR_OUT(RAM_ADR_OUT), .RAM_RD_OUT(RAM_RD_OUT), .RAM_WR_OUT(RAM_WR_OUT),
    .RAM_WR_DAT_OUT(RAM_WR_DAT_OUT), .RAM_WR_STRB_OUT(RAM_WR_STRB_OUT),
    .RAM_RD_DAT_IN(RAM_RD_DAT_IN)
  );

  // Single-port RAM with 2-cycle read latency and byte strobes
  logic [31:0] init_mem [NWORDS];
  logic [31:0] ram_mem  [NWORDS];
  logic [31:0] rd_p0, rd_p1;
  logic        load_req = 1'b0;

  always @(posedge CLK_IN) begin
    if (load_req) begin
      for (int k = 0; k < NWORDS; k++) ram_mem[k] <= init_mem[k];
    end else if (RAM_WR_OUT) begin
      for (int b = 0; b < 4; b++)
        if (RAM_WR_STRB_OUT[b]) ram_mem[RAM_ADR_OUT[9:2]][8*b +: 8] <= RAM_WR_DAT_OUT[8*b +: 8];
    end
    if (RAM_RD_OUT) rd_p0 <= ram_mem[RAM_ADR_OUT[9:2]];
    rd_p1 <= rd_p0;
  end
  assign RAM_RD_DAT_IN = rd_p1;

  // Reference model: expected returns queued with their due cycle
  typedef struct {
    int          due;
    bit          port;
    logic [31:0] dat;
  } ret_t;

  ret_t         pend_q[$];
  logic [31:0]  ref_mem [NWORDS];
  bit           model_last = 1'b1;
  int           cyc = 0;
  bit           exp_issue, exp_rd, exp_wr, exp_gnt;
  logic [147:0] exp_full, obs_full;
  int           checks = 0;
  int           failures = 0;
  bit           i_acked = 1'b0;
  bit           d_acked = 1'b0;

  task automatic eval_cycle();
    bit          i_req, d_req, ivld, dvld;
    logic [31:0] idat, ddat;
    logic [3:0]  strb;
    i_req     = I_RD_IN;
    d_req     = D_RD_IN || D_WR_IN;
    exp_issue = !RST_IN && !INIT_BUSY_IN && (i_req || d_req);
    if (i_req && d_req) exp_gnt = RR ? !model_last : 1'b1;
    else                exp_gnt = d_req;
    exp_wr = exp_issue && exp_gnt && D_WR_IN;
    exp_rd = exp_issue && !exp_wr;
    ivld = 1'b0; dvld = 1'b0; idat = '0; ddat = '0;
    if (!RST_IN && pend_q.size() > 0 && pend_q[0].due == cyc) begin
      if (pend_q[0].port) begin dvld = 1'b1; ddat = pend_q[0].dat; end
      else                begin ivld = 1'b1; idat = pend_q[0].dat; end
    end
    strb = exp_wr ? D_WR_STRB_IN : 4'h0;
    exp_full = {exp_issue && !exp_gnt, exp_issue && exp_gnt, exp_rd, exp_wr, ivld, dvld, strb,
                exp_issue ? (exp_gnt ? D_ADR_IN : I_ADR_IN) : 10'h0,
                exp_wr ? D_WR_DAT_IN : 32'h0, idat, ddat};
    obs_full = {I_ACK_OUT, D_ACK_OUT, RAM_RD_OUT, RAM_WR_OUT, I_RD_VLD_OUT, D_RD_VLD_OUT,
                RAM_WR_STRB_OUT, exp_issue ? RAM_ADR_OUT : 10'h0,
                exp_wr ? RAM_WR_DAT_OUT : 32'h0,
                ivld ? I_RD_DAT_OUT : 32'h0, dvld ? D_RD_DAT_OUT : 32'h0};
    i_acked = I_ACK_OUT;
    d_acked = D_ACK_OUT;
  endtask

  task automatic model_commit();
    ret_t r;
    if (RST_IN) begin
      pend_q.delete();
      model_last = 1'b1;
    end else begin
      if (pend_q.size() > 0 && pend_q[0].due == cyc) void'(pend_q.pop_front());
      if (exp_rd) begin
        r.due  = cyc + 2;
        r.port = exp_gnt;
        r.dat  = ref_mem[exp_gnt ? D_ADR_IN[9:2] : I_ADR_IN[9:2]];
        pend_q.push_back(r);
      end
      if (exp_wr) begin
        for (int b = 0; b < 4; b++)
          if (D_WR_STRB_IN[b]) ref_mem[D_ADR_IN[9:2]][8*b +: 8] = D_WR_DAT_IN[8*b +: 8];
      end
      if (exp_issue) model_last = exp_gnt;
    end
    cyc++;
  endtask

  task automatic idle_inputs();
    RST_IN = 1'b0; INIT_BUSY_IN = 1'b0; I_RD_IN = 1'b0; D_RD_IN = 1'b0; D_WR_IN = 1'b0;
    D_WR_STRB_IN = 4'h0; load_req = 1'b0;
  endtask

  task automatic test_reset();
    for (int t = 0; t < 5; t++) begin
      RST_IN = (t < 3); I_RD_IN = (t < 3); D_WR_IN = (t < 3);
      D_WR_STRB_IN = 4'hF; load_req = (t == 0);
      @(negedge CLK_IN); eval_cycle(); checks++;
      if (obs_full !== exp_full) begin
        failures++; $display("FAIL reset t=%0d got=%h exp=%h", t, obs_full, exp_full);
      end
      model_commit(); @(posedge CLK_IN); #1;
    end
    idle_inputs();
  endtask

  task automatic test_port0_reads();
    int vld_cnt = 0;
    for (int t = 0; t < 6; t++) begin
      I_RD_IN = (t < 3); I_ADR_IN = 10'(t * 4);
      @(negedge CLK_IN); eval_cycle(); checks++;
      if (obs_full !== exp_full) begin
        failures++; $display("FAIL port0_reads t=%0d got=%h exp=%h", t, obs_full, exp_full);
      end
      if (I_RD_VLD_OUT === 1'b1) vld_cnt++;
      model_commit(); @(posedge CLK_IN); #1;
    end
    idle_inputs();
    checks++;
    if (vld_cnt !== 3) begin
      failures++; $display("FAIL port0_vld_count got=%0d exp=3", vld_cnt);
    end
  endtask

  task automatic test_contention();
    int ia = 0, da = 0, iv = 0, dv = 0;
    I_ADR_IN = 10'h040; D_ADR_IN = 10'h100;
    for (int t = 0; t < 12; t++) begin
      I_RD_IN = (t <= 8); D_RD_IN = (t <= 7); D_WR_STRB_IN = 4'($urandom);
      @(negedge CLK_IN); eval_cycle(); checks++;
      if (obs_full !== exp_full) begin
        failures++; $display("FAIL contention t=%0d got=%h exp=%h", t, obs_full, exp_full);
      end
      ia += int'(I_ACK_OUT === 1'b1); da += int'(D_ACK_OUT === 1'b1);
      iv += int'(I_RD_VLD_OUT === 1'b1); dv += int'(D_RD_VLD_OUT === 1'b1);
      model_commit(); @(posedge CLK_IN); #1;
      if (i_acked) I_ADR_IN = I_ADR_IN + 10'd4;
      if (d_acked) D_ADR_IN = D_ADR_IN + 10'd4;
    end
    idle_inputs();
    checks++;
    if (ia !== EXP_I_ACKS || da !== EXP_D_ACKS || iv !== EXP_I_ACKS || dv !== EXP_D_ACKS) begin
      failures++;
      $display("FAIL contention_counts got i_ack=%0d d_ack=%0d i_vld=%0d d_vld=%0d exp i=%0d d=%0d",
               ia, da, iv, dv, EXP_I_ACKS, EXP_D_ACKS);
    end
  endtask

  task automatic test_write_strobe();
    logic [31:0] want;
    want = {init_mem[4][31:16], 16'hA5A5};
    for (int t = 0; t < 5; t++) begin
      D_ADR_IN = 10'h010; D_WR_DAT_IN = 32'hA5A5_A5A5;
      D_WR_STRB_IN = (t == 0) ? 4'b0011 : 4'b1100;
      D_WR_IN = (t == 0); D_RD_IN = (t <= 1);
      @(negedge CLK_IN); eval_cycle(); checks++;
      if (obs_full !== exp_full) begin
        failures++; $display("FAIL write_strobe t=%0d got=%h exp=%h", t, obs_full, exp_full);
      end
      if (t == 3) begin
        checks++;
        if (D_RD_VLD_OUT !== 1'b1 || D_RD_DAT_OUT !== want) begin
          failures++; $display("FAIL write_readback got vld=%b dat=%h exp vld=1 dat=%h",
                               D_RD_VLD_OUT, D_RD_DAT_OUT, want);
        end
      end
      model_commit(); @(posedge CLK_IN); #1;
    end
    idle_inputs();
  endtask

  task automatic test_init_busy();
    int busy_acks = 0, post_ack = 0;
    for (int t = 0; t < 10; t++) begin
      INIT_BUSY_IN = (t >= 1 && t <= 5);
      I_RD_IN = (t <= 6); I_ADR_IN = (t == 0) ? 10'h020 : 10'h024;
      @(negedge CLK_IN); eval_cycle(); checks++;
      if (obs_full !== exp_full) begin
        failures++; $display("FAIL init_busy t=%0d got=%h exp=%h", t, obs_full, exp_full);
      end
      if (t >= 1 && t <= 5) busy_acks += int'(I_ACK_OUT === 1'b1);
      if (t == 6) post_ack = int'(I_ACK_OUT === 1'b1);
      model_commit(); @(posedge CLK_IN); #1;
    end
    idle_inputs();
    checks++;
    if (busy_acks !== 0 || post_ack !== 1) begin
      failures++; $display("FAIL init_busy_acks got busy=%0d after=%0d exp busy=0 after=1", busy_acks, post_ack);
    end
  endtask

  task automatic test_reset_midop();
    int vld_cnt = 0;
    for (int t = 0; t < 7; t++) begin
      RST_IN = (t == 1); I_RD_IN = (t == 0); I_ADR_IN = 10'h030;
      D_WR_IN = (t == 1); D_WR_STRB_IN = 4'hF;
      @(negedge CLK_IN); eval_cycle(); checks++;
      if (obs_full !== exp_full) begin
        failures++; $display("FAIL reset_midop t=%0d got=%h exp=%h", t, obs_full, exp_full);
      end
      if (t >= 1) vld_cnt += int'(I_RD_VLD_OUT === 1'b1) + int'(D_RD_VLD_OUT === 1'b1);
      model_commit(); @(posedge CLK_IN); #1;
    end
    idle_inputs();
    checks++;
    if (vld_cnt !== 0) begin
      failures++; $display("FAIL reset_midop_vld got=%0d exp=0", vld_cnt);
    end
  endtask

  task automatic test_random();
    int k;
    i_acked = 1'b0; d_acked = 1'b0;
    for (int t = 0; t < 400; t++) begin
      INIT_BUSY_IN = ($urandom_range(0, 9) == 0);
      if (!(I_RD_IN && !i_acked)) begin
        I_RD_IN  = ($urandom_range(0, 99) < 60);
        I_ADR_IN = 10'($urandom_range(0, 255) * 4);
      end
      if (D_RD_IN && D_WR_IN && d_acked) begin
        D_WR_IN = 1'b0;
      end else if (!((D_RD_IN || D_WR_IN) && !d_acked)) begin
        k = $urandom_range(0, 9);
        D_RD_IN      = (k < 3) || (k == 6);
        D_WR_IN      = (k >= 3 && k <= 6);
        D_ADR_IN     = 10'($urandom_range(0, 255) * 4);
        D_WR_DAT_IN  = $urandom;
        D_WR_STRB_IN = 4'($urandom);
      end
      @(negedge CLK_IN); eval_cycle(); checks++;
      if (obs_full !== exp_full) begin
        failures++; $display("FAIL random t=%0d got=%h exp=%h", t, obs_full, exp_full);
      end
      model_commit(); @(posedge CLK_IN); #1;
    end
    idle_inputs();
    for (int t = 0; t < 3; t++) begin
      @(negedge CLK_IN); eval_cycle(); checks++;
      if (obs_full !== exp_full) begin
        failures++; $display("FAIL random_drain t=%0d got=%h exp=%h", t, obs_full, exp_full);
      end
      model_commit(); @(posedge CLK_IN); #1;
    end
  endtask

  initial begin
    for (int k = 0; k < NWORDS; k++) begin
      init_mem[k] = $urandom;
      ref_mem[k]  = init_mem[k];
    end
    @(posedge CLK_IN); #1;
    test_reset();
    test_port0_reads();
    test_contention();
    test_write_strobe();
    test_init_busy();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
